// File: rtl/serial_shift_rotate_unit.sv
// serial_shift_rotate_unit: iterative shift/rotate unit, one bit per clock.
// SHL/SHR/ROL/ROR/SRA with valid/ready on both request and result sides.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     request handshake
//   in_operand/in_shamt   value and bit count (sampled on accept)
//   in_mode               0 SHL,1 SHR,2 ROL,3 ROR,4 SRA; 5-7 illegal
//   out_valid/out_ready   result handshake
//   out_result/out_error  result value, illegal-mode flag
//   busy                  high whenever not IDLE
module serial_shift_rotate_unit #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_operand,
  input  logic [SHAMT_WIDTH-1:0] in_shamt,
  input  logic [2:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic                   out_error,
  output logic                   busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int XW = SHAMT_WIDTH + 1;
  localparam logic [XW-1:0] WX = XW'(WIDTH);

  localparam logic [2:0] M_SHL = 3'd0;
  localparam logic [2:0] M_SHR = 3'd1;
  localparam logic [2:0] M_ROL = 3'd2;
  localparam logic [2:0] M_ROR = 3'd3;
  localparam logic [2:0] M_SRA = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic [2:0]       mode_q;
  logic             err_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             busy_q;

  logic             legal_d;
  logic             rot_d;
  logic [XW-1:0]    sh_x;
  logic [XW-1:0]    eff_x;
  logic [CW-1:0]    cnt_d;

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] r,
    input logic [2:0]       m
  );
    logic [WIDTH-1:0] s;
    s = r;
    unique case (1'b1)
      (m == M_SHL): s = {r[WIDTH-2:0], 1'b0};
      (m == M_SHR): s = {1'b0, r[WIDTH-1:1]};
      (m == M_ROL): s = {r[WIDTH-2:0], r[WIDTH-1]};
      (m == M_ROR): s = {r[0], r[WIDTH-1:1]};
      (m == M_SRA): s = {r[WIDTH-1], r[WIDTH-1:1]};
      default:      s = r;
    endcase
    return s;
  endfunction

  // Out-of-range amounts: rotates wrap, shifts saturate at WIDTH steps.
  always_comb begin
    legal_d = (in_mode <= M_SRA);
    rot_d   = (in_mode == M_ROL) || (in_mode == M_ROR);
    sh_x    = {1'b0, in_shamt};
    eff_x   = sh_x;
    if (sh_x >= WX) begin
      eff_x = rot_d ? (sh_x - WX) : WX;
    end
    cnt_d = CW'(eff_x);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      res_q       <= '0;
      mode_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            res_q      <= in_operand;
            mode_q     <= in_mode;
            err_q      <= !legal_d;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (!legal_d || cnt_d == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
              cnt_q   <= cnt_d;
            end
          end
        end
        SHIFT: begin
          res_q <= step(res_q, mode_q);
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_error  = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_shift_rotate_unit.sv
// tb_serial_shift_rotate_unit: directed bench for the shift/rotate unit.
// Hand-computed vectors, immediate assertions at each comparison.
module tb_serial_shift_rotate_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_operand;
  logic [4:0]  in_shamt;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_error;
  logic        busy;

  int vectors;
  int miscompares;
  int last_busy;

  serial_shift_rotate_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_operand (in_operand),
    .in_shamt   (in_shamt),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_error  (out_error),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, optionally stall the result, then handshake it.
  task automatic do_op(
    input string       tag,
    input logic [31:0] op,
    input logic [4:0]  sh,
    input logic [2:0]  md,
    input logic [31:0] er,
    input logic        ee,
    input int          el,
    input int          hold
  );
    int n;
    int bc;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_operand = op;
    in_shamt   = sh;
    in_mode    = md;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_operand = ~op;
    in_shamt   = ~sh;
    in_mode    = 3'd1;
    n  = 0;
    bc = 0;
    while (!out_valid && n < 200) begin
      if (busy) bc++;
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) bc++;
    last_busy = bc;
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".result"}, out_result, er);
    chk({tag, ".error"}, {31'd0, out_error}, {31'd0, ee});
    chk({tag, ".latency"}, n + 1, el);
    for (int i = 0; i < hold; i++) begin
      if (i == 2) begin
        in_operand = 32'h0000_00FF;
        in_shamt   = 5'd1;
        in_mode    = 3'd0;
        in_valid   = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({tag, ".hold_result"}, out_result, er);
      chk({tag, ".hold_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".drop_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".err_clr"}, {31'd0, out_error}, 32'd0);
    chk({tag, ".busy_clr"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_busy   = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_operand  = '0;
    in_shamt    = '0;
    in_mode     = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_error", {31'd0, out_error}, 32'd0);
    chk("rst.out_result", out_result, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("shl4", 32'h0000_0001, 5'd4, 3'd0, 32'h0000_0010, 1'b0, 5, 0);
    chk("shl4.busy_cycles", last_busy, 5);
    do_op("ror1", 32'h0000_0001, 5'd1, 3'd3, 32'h8000_0000, 1'b0, 2, 0);
    do_op("rol31", 32'h8000_0001, 5'd31, 3'd2, 32'hC000_0000, 1'b0, 32, 0);
    do_op("rol0", 32'h1234_5678, 5'd0, 3'd2, 32'h1234_5678, 1'b0, 1, 0);
    do_op("sra31", 32'h8000_0000, 5'd31, 3'd4, 32'hFFFF_FFFF, 1'b0, 32, 0);
    do_op("shr31", 32'h8000_0000, 5'd31, 3'd1, 32'h0000_0001, 1'b0, 32, 0);
    do_op("sra30", 32'h4000_0000, 5'd30, 3'd4, 32'h0000_0001, 1'b0, 31, 0);
    do_op("rol1", 32'h8000_0001, 5'd1, 3'd2, 32'h0000_0003, 1'b0, 2, 0);

    do_op("bp", 32'h0000_00A5, 5'd3, 3'd0, 32'h0000_0528, 1'b0, 4, 6);
    do_op("bp_next", 32'h0000_0F00, 5'd8, 3'd1, 32'h0000_000F, 1'b0, 9, 0);

    do_op("illegal", 32'hDEAD_BEEF, 5'd9, 3'd7, 32'hDEAD_BEEF, 1'b1, 1, 0);
    do_op("post_ill", 32'h0000_00F0, 5'd4, 3'd1, 32'h0000_000F, 1'b0, 5, 0);

    in_operand = 32'h0000_0001;
    in_shamt   = 5'd20;
    in_mode    = 3'd0;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid.busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid.in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid.busy_low", {31'd0, busy}, 32'd0);
    chk("mid.result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op("fresh", 32'h0000_0003, 5'd2, 3'd0, 32'h0000_000C, 1'b0, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
